// File: rtl/obi_pkg.sv
// OBI bus payload types shared by the peripheral interconnect.
package obi_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned BeWidth   = DataWidth / 8;

  typedef struct packed {
    logic                 req;
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [BeWidth-1:0]   be;
    logic [DataWidth-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic                 gnt;
    logic                 rvalid;
    logic [DataWidth-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/periph_arb_pkg.sv
// Index type and round-robin helpers for the peripheral OBI arbiter.
package periph_arb_pkg;

  localparam int unsigned ArbNumMasters     = 3;
  localparam int unsigned ArbMaxOutstanding = 2;
  localparam int unsigned IdxWidth          = $clog2(ArbNumMasters);

  typedef logic [IdxWidth-1:0]      idx_t;
  typedef logic [ArbNumMasters-1:0] req_vec_t;

  // First requester at or after ptr, wrapping; returns ptr when nobody requests.
  function automatic idx_t rr_pick(input req_vec_t req_vec, input idx_t ptr);
    idx_t        pick;
    logic        found;
    int unsigned cand;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < ArbNumMasters; k++) begin
      cand = (32'(ptr) + k) % ArbNumMasters;
      if (!found && req_vec[IdxWidth'(cand)]) begin
        pick  = IdxWidth'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic idx_t idx_inc(input idx_t i);
    return (32'(i) == ArbNumMasters - 1) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/periph_obi_rr_arbiter_fifo.sv
// In-order FIFO of granted master indices; push is accepted when full if a pop happens too.
module periph_obi_rr_arbiter_fifo
  import periph_arb_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter int unsigned CntWidth = $clog2(Depth) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  idx_t                data_i,
  input  logic                pop_i,
  output idx_t                data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] usage_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  idx_t                mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                do_push, do_pop;

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CntWidth'(do_push) - CntWidth'(do_pop);
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/periph_obi_rr_arbiter.sv
// Round-robin OBI arbiter in front of peripheral_subsystem with in-order response routing.
module periph_obi_rr_arbiter
  import obi_pkg::*;
  import periph_arb_pkg::*;
#(
  parameter int unsigned NumMasters     = ArbNumMasters,
  parameter int unsigned MaxOutstanding = ArbMaxOutstanding
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  master_req_i  [NumMasters],
  output obi_resp_t master_resp_o [NumMasters],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i,
  output logic      busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding) + 1;

  req_vec_t            req_vec;
  idx_t                sel, fifo_head;
  logic                any_req, issue, grant, pop;
  logic                fifo_full, fifo_empty;
  logic [CntWidth-1:0] fifo_usage;
  logic                lock_q, lock_d;
  idx_t                locked_idx_q, locked_idx_d;
  idx_t                rr_ptr_q, rr_ptr_d;

  for (genvar g = 0; g < NumMasters; g++) begin : gen_master
    logic rsp_hit;
    assign req_vec[g]               = master_req_i[g].req;
    assign rsp_hit                  = pop & (fifo_head == IdxWidth'(g));
    assign master_resp_o[g].gnt     = grant & (sel == IdxWidth'(g));
    assign master_resp_o[g].rvalid  = rsp_hit;
    assign master_resp_o[g].rdata   = rsp_hit ? slave_resp_i.rdata : '0;
  end

  // Pop-before-push: a response this cycle frees a slot for a grant this cycle.
  assign any_req     = |req_vec;
  assign pop         = slave_resp_i.rvalid & ~fifo_empty;
  assign issue       = any_req & (~fifo_full | pop);
  assign sel         = lock_q ? locked_idx_q : rr_pick(req_vec, rr_ptr_q);
  assign slave_req_o = issue ? master_req_i[sel] : '0;
  assign grant       = slave_resp_i.gnt & slave_req_o.req;
  assign busy_o      = (fifo_usage != '0) | any_req;

  always_comb begin
    lock_d       = lock_q;
    locked_idx_d = locked_idx_q;
    rr_ptr_d     = rr_ptr_q;
    if (grant) begin
      lock_d   = 1'b0;
      rr_ptr_d = idx_inc(sel);
    end else if (slave_req_o.req) begin
      lock_d       = 1'b1;
      locked_idx_d = sel;
    end else if (lock_q) begin
      // Locked master withdrew its request before the grant.
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      lock_q       <= lock_d;
      locked_idx_q <= locked_idx_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  periph_obi_rr_arbiter_fifo #(
    .Depth    (MaxOutstanding),
    .CntWidth (CntWidth)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  a_rvalid_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    slave_resp_i.rvalid |-> !fifo_empty);

  a_locked_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> master_req_i[locked_idx_q].req);

endmodule

// File: tb/tb_periph_obi_rr_arbiter.sv
// Randomised scoreboard bench for periph_obi_rr_arbiter against a transaction-level model.
module tb_periph_obi_rr_arbiter;
  import obi_pkg::*;

  localparam int unsigned NM = 3;
  localparam int unsigned MO = 2;

  logic      clk = 1'b0;
  logic      rst_n;
  obi_req_t  m_req  [NM];
  obi_resp_t m_resp [NM];
  obi_req_t  s_req;
  obi_resp_t s_resp;
  logic      busy;

  always #5 clk = ~clk;

  periph_obi_rr_arbiter #(
    .NumMasters     (NM),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .master_req_i  (m_req),
    .master_resp_o (m_resp),
    .slave_req_o   (s_req),
    .slave_resp_i  (s_resp),
    .busy_o        (busy)
  );

  typedef struct {
    obi_req_t sreq;
    int       gnt_idx;
    bit       busy;
  } exp_cyc_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_rsp_t;

  int       n_chk = 0;
  int       n_fail = 0;
  int       p_req = 0;
  exp_cyc_t cyc_q [$];
  exp_rsp_t rsp_q [$];
  int       gnt_log [$];
  obi_req_t mst [NM];

  // Reference model: arbitration pointer, lock and in-order list of granted masters.
  int mdl_ptr = 0;
  bit mdl_lock = 0;
  int mdl_lidx = 0;
  int inflight [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic obi_req_t rand_req();
    obi_req_t r;
    r.req   = 1'b1;
    r.addr  = $urandom() & 32'hFFFF_FFFC;
    r.we    = 1'($urandom_range(1));
    r.be    = 4'($urandom());
    r.wdata = $urandom();
    return r;
  endfunction

  function automatic bit any_active();
    bit a = 0;
    for (int i = 0; i < NM; i++) a |= mst[i].req;
    return a;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a cycle or a response.
  always @(negedge clk) begin : mon
    exp_cyc_t e;
    exp_rsp_t r;
    if (rst_n) begin
      for (int i = 0; i < NM; i++) if (m_resp[i].gnt) gnt_log.push_back(i);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("slave_req", 128'(s_req), 128'(e.sreq));
        for (int i = 0; i < NM; i++)
          chk($sformatf("gnt_m%0d", i), 128'(m_resp[i].gnt), 128'(e.gnt_idx == i));
        chk("busy", 128'(busy), 128'(e.busy));
      end
      for (int i = 0; i < NM; i++) begin
        if (m_resp[i].rvalid) begin
          if (rsp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rvalid_unexpected: m%0d got rvalid, expected none", i);
          end else begin
            r = rsp_q.pop_front();
            chk("rsp_idx", 128'(i), 128'(r.idx));
            chk("rsp_data", 128'(m_resp[i].rdata), 128'(r.data));
          end
        end else begin
          chk($sformatf("rdata_idle_m%0d", i), 128'(m_resp[i].rdata), 128'(0));
        end
      end
    end
  end

  // One bus cycle: drive inputs, predict outputs, advance model and masters.
  task automatic step(input bit g, input bit rv, input logic [31:0] rd);
    bit       any, full, pop, issue;
    int       sel;
    exp_cyc_t e;
    exp_rsp_t r;
    any = any_active();
    for (int i = 0; i < NM; i++) m_req[i] = mst[i];
    pop           = rv && (inflight.size() > 0);
    s_resp.gnt    = g;
    s_resp.rvalid = pop;
    s_resp.rdata  = rd;
    full = (inflight.size() >= MO);
    sel  = 0;
    if (mdl_lock) sel = mdl_lidx;
    else begin
      for (int k = NM - 1; k >= 0; k--)
        if (mst[(mdl_ptr + k) % NM].req) sel = (mdl_ptr + k) % NM;
    end
    issue     = any && (!full || pop);
    e.sreq    = issue ? mst[sel] : '0;
    e.gnt_idx = (issue && mst[sel].req && g) ? sel : -1;
    e.busy    = (inflight.size() != 0) || any;
    if (pop) begin
      r.idx  = inflight[0];
      r.data = rd;
      rsp_q.push_back(r);
    end
    cyc_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("rsp_delivered", 128'(rsp_q.size()), 128'(0));
    if (pop) void'(inflight.pop_front());
    if (e.gnt_idx >= 0) begin
      inflight.push_back(sel);
      mdl_ptr  = (sel + 1) % NM;
      mdl_lock = 0;
      mst[sel] = '0;
    end else if (issue && mst[sel].req) begin
      mdl_lock = 1;
      mdl_lidx = sel;
    end
    for (int i = 0; i < NM; i++)
      if (!mst[i].req && ($urandom_range(99) < p_req)) mst[i] = rand_req();
  endtask

  task automatic drain();
    p_req = 0;
    for (int k = 0; k < 60 && (inflight.size() > 0 || any_active()); k++) step(1, 1, $urandom());
    for (int i = 0; i < NM; i++) m_req[i] = mst[i];
    s_resp = '0;
    #1;
    chk("drain_busy", 128'(busy), 128'(0));
  endtask

  initial begin : wdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int start;
    rst_n  = 1'b0;
    s_resp = '0;
    for (int i = 0; i < NM; i++) begin
      mst[i]   = '0;
      m_req[i] = '0;
    end
    #12;
    chk("rst_slave_req", 128'(s_req), 128'(0));
    for (int i = 0; i < NM; i++) chk("rst_resp", 128'(m_resp[i]), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write from m0, response next cycle.
    mst[0] = '{req: 1'b1, addr: 32'h2000_0010, we: 1'b1, be: 4'hF, wdata: 32'h1234_5678};
    step(1, 0, 32'h0);
    step(0, 1, 32'hDEAD_BEEF);
    step(0, 0, 32'h0);
    chk("t1_busy_low", 128'(busy), 128'(0));

    // All masters request continuously with an always-granting slave.
    for (int i = 0; i < NM; i++) mst[i] = rand_req();
    p_req = 100;
    gnt_log.delete();
    start = mdl_ptr;
    for (int k = 0; k < 9; k++) step(1, 1, $urandom());
    chk("t2_grant_count", 128'(gnt_log.size()), 128'(9));
    for (int k = 0; k < 9 && k < gnt_log.size(); k++)
      chk($sformatf("t2_order_%0d", k), 128'(gnt_log[k]), 128'((start + k) % NM));
    drain();

    // m1 stalls on gnt=0 while m0 joins; m1 must stay on the bus until granted.
    mst[1] = rand_req();
    step(0, 0, 32'h0);
    mst[0] = rand_req();
    step(0, 0, 32'h0);
    step(0, 0, 32'h0);
    gnt_log.delete();
    step(1, 0, 32'h0);
    step(1, 0, 32'h0);
    chk("t3_grant_count", 128'(gnt_log.size()), 128'(2));
    if (gnt_log.size() == 2) begin
      chk("t3_first", 128'(gnt_log[0]), 128'(1));
      chk("t3_second", 128'(gnt_log[1]), 128'(0));
    end
    drain();

    // Outstanding limit without responses, then a response re-opens the port.
    for (int i = 0; i < NM; i++) mst[i] = rand_req();
    p_req = 100;
    for (int k = 0; k < 4; k++) step(1, 0, 32'h0);
    step(1, 1, $urandom());
    step(1, 1, $urandom());
    drain();

    // m2 then m0 granted; responses must be routed in grant order.
    mst[2] = rand_req();
    step(1, 0, 32'h0);
    mst[0] = rand_req();
    step(1, 0, 32'h0);
    step(0, 1, 32'hA5A5_A5A5);
    step(0, 1, 32'h5A5A_5A5A);
    drain();

    // Random traffic.
    p_req = 40;
    for (int k = 0; k < 1500; k++)
      step($urandom_range(99) < 60, $urandom_range(99) < 50, $urandom());
    drain();

    // Reset with one outstanding transaction and a locked master.
    mst[0] = rand_req();
    step(1, 0, 32'h0);
    mst[1] = rand_req();
    step(0, 0, 32'h0);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NM; i++) begin
      mst[i]   = '0;
      m_req[i] = '0;
    end
    s_resp = '0;
    #1;
    chk("t6_rst_slave_req", 128'(s_req), 128'(0));
    for (int i = 0; i < NM; i++) chk("t6_rst_resp", 128'(m_resp[i]), 128'(0));
    chk("t6_rst_busy", 128'(busy), 128'(0));
    mdl_ptr  = 0;
    mdl_lock = 0;
    inflight.delete();
    cyc_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NM; i++) mst[i] = rand_req();
    gnt_log.delete();
    step(1, 0, 32'h0);
    chk("t6_m0_priority", 128'(gnt_log.size() > 0 ? gnt_log[0] : -1), 128'(0));
    drain();

    chk("cyc_q_empty", 128'(cyc_q.size()), 128'(0));
    chk("rsp_q_empty", 128'(rsp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
